// File: rtl/gate_truth_scanner.sv
// Truth-table scanner: walks vec through all 2^N_IN codes, samples a built-in gate
// or ext_y after each dwell, and compares the table. Optional err_cnt via GTS_ERRCNT_EN.
module gate_truth_scanner #(
  parameter int N_IN  = 2,
  parameter int DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2:0]             op,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   ext_y,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [7:0]             err_cnt
);

  localparam int TW = 1 << N_IN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_MAX    = '1;
  localparam logic [N_IN-1:0] VEC_ONE    = 1;

  logic [1:0]      state_q, state_d;
  logic [7:0]      dwell_q, dwell_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [TW-1:0]   table_q, table_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic [2:0]      op_q, op_d;
  logic            pass_q, pass_d;

  logic            y;
  logic [TW-1:0]   sampled_table;
  logic            accept;
  logic            sample_now;
  logic            last_sample;

  always_comb begin
    y = 1'b0;
    case (op_q)
      3'b000:  y = ~&vec_q;
      3'b001:  y = ~|vec_q;
      3'b010:  y = &vec_q;
      3'b011:  y = |vec_q;
      3'b100:  y = ^vec_q;
      3'b101:  y = ~^vec_q;
      3'b110:  y = ~vec_q[0];
      default: y = ext_y;
    endcase
  end

  // Table as it would look after writing the current sample; feeds both the
  // stored table and the final comparison so pass is valid alongside done.
  always_comb begin
    sampled_table        = table_q;
    sampled_table[vec_q] = y;
  end

  assign accept      = (state_q == S_IDLE) && start && !abort;
  assign sample_now  = (state_q == S_RUN) && !abort && (dwell_q == DWELL_LAST);
  assign last_sample = sample_now && (vec_q == VEC_MAX);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    vec_d   = vec_q;
    table_d = table_q;
    exp_d   = exp_q;
    op_d    = op_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op;
          exp_d   = expected;
          table_d = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          dwell_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (sample_now) begin
          dwell_d = '0;
          table_d = sampled_table;
          if (last_sample) begin
            pass_d  = (sampled_table == exp_q);
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + VEC_ONE;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
      vec_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      op_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      op_q    <= op_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GTS_ERRCNT_EN
  logic [7:0] err_q, err_d, pop;

  // Saturating popcount of mismatching bits in the final table.
  always_comb begin
    pop = '0;
    for (int i = 0; i < TW; i++) begin
      if ((sampled_table[i] != exp_q[i]) && (pop != 8'hFF)) pop = pop + 8'd1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept)           err_d = '0;
    else if (last_sample) err_d = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign vec       = vec_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign table_out = table_q;

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Directed bench for gate_truth_scanner: table of per-gate scans on a 2-input
// instance plus abort, reset and 3-input XOR sequences.
module tb_gate_truth_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, ext_y;
  logic [2:0] op;
  logic [3:0] expected;
  logic [1:0] vec;
  logic       busy, done, pass;
  logic [3:0] table_out;
  logic [7:0] err_cnt;
  logic [1:0] ext_mode;

  assign ext_y = (ext_mode == 2'd2) ? vec[1] : ext_mode[0];

  gate_truth_scanner #(.N_IN(2), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
    .expected(expected), .ext_y(ext_y), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .table_out(table_out), .err_cnt(err_cnt)
  );

  logic       start2, abort2, ext_y2;
  logic [2:0] op2;
  logic [7:0] expected2;
  logic [2:0] vec2;
  logic       busy2, done2, pass2;
  logic [7:0] table2;
  logic [7:0] err2;

  gate_truth_scanner #(.N_IN(3), .DWELL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .op(op2),
    .expected(expected2), .ext_y(ext_y2), .vec(vec2), .busy(busy2), .done(done2),
    .pass(pass2), .table_out(table2), .err_cnt(err2)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] expected;
    logic [1:0] ext_mode;
    bit         inject;
    logic [3:0] exp_table;
    bit         exp_pass;
  } vec_t;

  vec_t vectors[10];
  int   n_cmp  = 0;
  int   n_miss = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_err(input logic [3:0] t, input logic [3:0] e);
    logic [7:0] r;
    r = 8'($countones(t ^ e));
`ifndef GTS_ERRCNT_EN
    r = 8'd0;
`endif
    return r;
  endfunction

  // Run one full scan on the 2-input instance and check timing, sequence and results.
  task automatic apply_stimulus(input int idx, input vec_t v);
    int k;
    bit seq_ok;
    op       = v.op;
    expected = v.expected;
    ext_mode = v.ext_mode;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    k      = 0;
    seq_ok = 1'b1;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (v.inject && k == 7) begin
        start    = 1'b1;
        op       = 3'b111;
        expected = 4'hA;
      end else if (v.inject && k == 8) begin
        start = 1'b0;
      end
      if (!done && (!busy || vec !== 2'(k / 4))) seq_ok = 1'b0;
    end
    check_output($sformatf("v%0d done latency", idx), 64'(k), 64'd16);
    check_output($sformatf("v%0d vec sequence", idx), 64'(seq_ok), 64'd1);
    check_output($sformatf("v%0d table_out", idx), 64'(table_out), 64'(v.exp_table));
    check_output($sformatf("v%0d pass", idx), 64'(pass), 64'(v.exp_pass));
    check_output($sformatf("v%0d err_cnt", idx), 64'(err_cnt), 64'(model_err(v.exp_table, v.expected)));
    check_output($sformatf("v%0d vec at end", idx), 64'(vec), 64'd3);
    @(posedge clk); #1;
    check_output($sformatf("v%0d done/busy after", idx), {62'd0, done, busy}, 64'd0);
    check_output($sformatf("v%0d table hold", idx), 64'(table_out), 64'(v.exp_table));
  endtask

  initial begin
    int  k;
    bit  done_seen;

    vectors[0] = '{3'b000, 4'b0111, 2'd0, 1'b0, 4'b0111, 1'b1};
    vectors[1] = '{3'b001, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1};
    vectors[2] = '{3'b110, 4'b0101, 2'd0, 1'b0, 4'b0101, 1'b1};
    vectors[3] = '{3'b010, 4'b1000, 2'd0, 1'b0, 4'b1000, 1'b1};
    vectors[4] = '{3'b011, 4'b1110, 2'd0, 1'b0, 4'b1110, 1'b1};
    vectors[5] = '{3'b100, 4'b0110, 2'd0, 1'b0, 4'b0110, 1'b1};
    vectors[6] = '{3'b101, 4'b0110, 2'd0, 1'b0, 4'b1001, 1'b0};
    vectors[7] = '{3'b111, 4'b0001, 2'd1, 1'b0, 4'b1111, 1'b0};
    vectors[8] = '{3'b111, 4'b1100, 2'd2, 1'b0, 4'b1100, 1'b1};
    vectors[9] = '{3'b000, 4'b0110, 2'd0, 1'b0, 4'b0111, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; expected = '0; ext_mode = '0;
    start2 = 1'b0; abort2 = 1'b0; ext_y2 = 1'b0; op2 = '0; expected2 = '0;
    #12;
    check_output("reset outputs", {table_out, err_cnt, vec, busy, done, pass}, 64'd0);
    check_output("reset outputs dut2", {table2, vec2, busy2, done2, pass2}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) apply_stimulus(i, vectors[i]);

    // Abort partway through a NAND scan: only vec 0 has been sampled.
    op = 3'b000; expected = 4'b0111; ext_mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_output("abort busy/done", {62'd0, busy, done}, 64'd0);
    check_output("abort pass", 64'(pass), 64'd0);
    check_output("abort table_out", 64'(table_out), 64'b0001);
    check_output("abort vec", 64'(vec), 64'd1);
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    check_output("abort no done", 64'(done_seen), 64'd0);

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_output("start+abort idle", 64'(busy), 64'd0);
    check_output("start+abort table hold", 64'(table_out), 64'b0001);

    // Asynchronous reset mid-scan, then a normal scan afterwards.
    op = 3'b000; expected = 4'b0111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("mid-scan reset", {table_out, err_cnt, vec, busy, done, pass}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_stimulus(10, vectors[0]);

    // Three-input XOR on the second instance.
    op2 = 3'b100; expected2 = 8'h96; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check_output("xor3 done latency", 64'(k), 64'd16);
    check_output("xor3 table_out", 64'(table2), 64'h96);
    check_output("xor3 pass", 64'(pass2), 64'd1);
    check_output("xor3 vec at end", 64'(vec2), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/gate_truth_scanner.md
# gate_truth_scanner

Sequential truth-table scanner for the logic-design lab library. It replaces hand-written per-gate stimulus blocks with one parametrised engine. The engine steps an N-input vector through all 2^N_IN combinations, holding each for a programmable dwell time. At the end of each dwell it samples either a built-in gate model or an external device under test, assembles the measured truth table, and reports pass/fail against an expected table.

## Interface
- N_IN, 2, number of gate inputs; legal range 1..6
- DWELL, 4, clock cycles each vector is held; legal range 1..255
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a scan; honoured only in IDLE
- abort  input  1  terminate a scan in progress
- op  input  3  function select, latched at start:
  - 000 NAND, 001 NOR, 010 AND, 011 OR, 100 XOR, 101 XNOR
  - 110 NOT of vec[0]
  - 111 external (uses ext_y)
- expected  input  2^N_IN  expected truth table, latched at start; bit i is the output for vec=i
- ext_y  input  1  external DUT output, driven combinationally from vec
- vec  output  N_IN  vector currently applied
- busy  output  1  high while a scan is running
- done  output  1  one-cycle pulse when a scan completes
- pass  output  1  measured table equals the latched expected table
- table_out  output  2^N_IN  measured truth table
- err_cnt  output  8  count of mismatching table bits (see Configuration)

## Operation
- Internal model: y = reduction of vec by the selected gate. NAND is ~&vec, NOR is ~|vec, XOR is ^vec, XNOR is ~^vec. Op 110 gives y = ~vec[0]. Op 111 gives y = ext_y.
- FSM states: IDLE, RUN, DONE.
- IDLE, on start=1 and abort=0:
  - latch op and expected
  - clear table_out, pass, err_cnt, vec and dwell_cnt
  - go to RUN
- RUN:
  - dwell_cnt increments every cycle.
  - When dwell_cnt==DWELL-1: write y into table_out[vec] and reset dwell_cnt to 0.
  - If vec==2^N_IN-1, go to DONE. Otherwise vec increments.
- DONE (one cycle):
  - done=1
  - pass = (table_out == latched expected)
  - go to IDLE
- In IDLE, vec, table_out, pass and err_cnt hold their last values.
- abort=1 in RUN: go to IDLE at the next edge. No done pulse is generated, pass is forced to 0, and table_out keeps the partial table.
- start while busy: ignored.
- start and abort together in IDLE: abort wins and the block stays in IDLE.
- Changes on op or expected during RUN: ignored.

## Timing
- Reset values: vec=0, busy=0, done=0, pass=0, table_out=0, err_cnt=0, state IDLE, dwell_cnt=0.
- Reset asserted mid-scan returns the block to the reset values immediately, without waiting for a clock edge.
- start is sampled at edge E0. busy is high from E0 through the DONE cycle.
- vec changes every DWELL cycles. The first change is at E0+DWELL.
- Sampling takes place at edges E0+k·DWELL for k=1..2^N_IN. ext_y must therefore be stable at least one cycle before each sampling edge when DWELL≥2.
- done is high during the cycle after edge E0+2^N_IN·DWELL. The scan latency is 2^N_IN·DWELL+1 cycles.
- pass and err_cnt are valid in the same cycle as done and hold until the next accepted start.
- vec wrap: vec never increments past 2^N_IN-1, and it remains at 2^N_IN-1 after the scan.

## Configuration
- GTS_ERRCNT_EN defined:
  - In the DONE transition, err_cnt is set to the popcount of (table_out XOR expected).
  - The count saturates at 255.
  - err_cnt is cleared at an accepted start.
- GTS_ERRCNT_EN undefined: err_cnt is tied to 0 and no counter logic is synthesised. pass behaviour is unchanged.

## Test plan
- NAND: N_IN=2, DWELL=4, op=000, expected=4'b0111, start -> vec sequence 0,1,2,3 (4 cycles each), table_out=4'b0111, pass=1, done 17 cycles after start.
- NOR then NOT, back-to-back:
  - NOR: op=001, expected=4'b0001 -> pass=1.
  - NOT: op=110, expected=4'b0101 -> pass=1.
  - start raised during the NOR run is ignored.
- External mismatch: op=111, ext_y tied 1, expected=4'b0001 -> table_out=4'b1111, pass=0, err_cnt=3 (err_cnt=0 without GTS_ERRCNT_EN).
- XOR: N_IN=3, DWELL=2, op=100, expected=8'h96 -> table_out=8'h96, pass=1, done 17 cycles after start.
- Abort: abort at cycle 6 of a NAND scan (N_IN=2, DWELL=4) -> busy=0 next cycle, no done pulse, pass=0, table_out=4'b0001.
- Reset: rst_n low mid-scan -> all outputs at reset values immediately. A new start after release gives a normal full scan.
